bp_fpga_host_tx_arbiter: RTL

BP_FPGA_HOST_TX_ARBITER -- requirements
Module: bp_fpga_host_tx_arbiter

---
 rtl/bp_fpga_host_pkg.sv | 47 ++++
 rtl/bsg_arb_round_robin.sv | 34 +++
 rtl/bp_fpga_host_tx_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF definitions for the FPGA host transmit path: packet struct
// declaration macro, opcode enum, byte-count constants and the TX FSM states.
// Optional feature macro: BP_FPGA_HOST_TX_CHECKSUM_EN adds the checksum state.
`ifndef BP_FPGA_HOST_PKG_SV
`define BP_FPGA_HOST_PKG_SV

// Declares bp_fpga_host_nbf_s: opcode in the MSBs, data in the LSBs.
`define BP_FPGA_HOST_DECLARE_NBF_S(addr_width_mp, data_width_mp) \
   typedef struct packed { \
      logic [7:0]               opcode; \
      logic [addr_width_mp-1:0] addr; \
      logic [data_width_mp-1:0] data; \
   } bp_fpga_host_nbf_s

package bp_fpga_host_pkg;

   typedef enum logic [7:0] {
      e_nbf_wr4    = 8'h02,
      e_nbf_wr8    = 8'h03,
      e_nbf_rd4    = 8'h12,
      e_nbf_rd8    = 8'h13,
      e_nbf_fence  = 8'hFE,
      e_nbf_finish = 8'hFF
   } bp_fpga_host_nbf_opcode_e;

   localparam int nbf_opcode_width_gp = 8;
   localparam int nbf_addr_width_gp   = 40;
   localparam int nbf_data_width_gp   = 64;
   localparam int nbf_width_gp        = nbf_opcode_width_gp + nbf_addr_width_gp + nbf_data_width_gp;
   localparam int nbf_num_bytes_gp    = nbf_width_gp / 8;

   // Byte count for a non-default address/data sizing.
   function automatic int nbf_num_bytes(input int addr_w, input int data_w);
      return (nbf_opcode_width_gp + addr_w + data_w) / 8;
   endfunction

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_send = 2'd1
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
      ,e_csum = 2'd2
`endif
   } bp_fpga_host_tx_state_e;

endpackage

`endif

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin picker: the search starts one past last_i and
// wraps, so the most recently served requester has the lowest priority.
module bsg_arb_round_robin #(
   parameter  int width_p  = 2,
   localparam int id_w_lp  = (width_p > 1) ? $clog2(width_p) : 1
) (
   input  logic [width_p-1:0] reqs_i,
   input  logic [id_w_lp-1:0] last_i,
   output logic [width_p-1:0] grant_one_hot_o,
   output logic [id_w_lp-1:0] grant_id_o,
   output logic               v_o
);

   logic [id_w_lp-1:0] idx;
   logic               found;

   // Scan requesters in rotated priority order and take the first one set.
   always_comb begin
      grant_one_hot_o = '0;
      grant_id_o      = '0;
      idx             = '0;
      found           = 1'b0;
      for (int off = 1; off <= width_p; off++) begin
         idx = id_w_lp'((int'(last_i) + off) % width_p);
         if (!found && reqs_i[idx]) begin
            found                = 1'b1;
            grant_id_o           = idx;
            grant_one_hot_o[idx] = 1'b1;
         end
      end
      v_o = found;
   end

endmodule

// File: rtl/bp_fpga_host_tx_arbiter.sv
// Arbitrates NBF packets from several requesters onto one byte-wide UART TX.
// A granted packet is latched whole and streamed LSB byte first; the next
// grant is only considered after one idle cycle.
// Optional feature macro: BP_FPGA_HOST_TX_CHECKSUM_EN appends an XOR checksum byte.
module bp_fpga_host_tx_arbiter
   import bp_fpga_host_pkg::*;
#(
   parameter  int nbf_addr_width_p = 40,
   parameter  int nbf_data_width_p = 64,
   parameter  int num_src_p        = 2,
   parameter  int uart_data_bits_p = 8,
   localparam int nbf_width_lp     = nbf_opcode_width_gp + nbf_addr_width_p + nbf_data_width_p,
   localparam int src_id_width_lp  = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [num_src_p*nbf_width_lp-1:0] nbf_i,
   input  logic [num_src_p-1:0]              nbf_v_i,
   output logic [num_src_p-1:0]              nbf_yumi_o,
   output logic [uart_data_bits_p-1:0]       tx_data_o,
   output logic                              tx_v_o,
   input  logic                              tx_ready_and_i,
   output logic                              busy_o,
   output logic [src_id_width_lp-1:0]        grant_id_o
);

   localparam int num_bytes_lp = nbf_num_bytes(nbf_addr_width_p, nbf_data_width_p);
   localparam int cnt_width_lp = $clog2(num_bytes_lp + 1);
   localparam logic [cnt_width_lp-1:0] last_byte_lp = cnt_width_lp'(num_bytes_lp - 1);

   `BP_FPGA_HOST_DECLARE_NBF_S(nbf_addr_width_p, nbf_data_width_p);

   bp_fpga_host_tx_state_e state_q, state_d;
   logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
   logic [src_id_width_lp-1:0] last_grant_q, last_grant_d;
   logic [src_id_width_lp-1:0] grant_id_q, grant_id_d;
   logic [nbf_width_lp-1:0]    shift_q, shift_d;
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
   logic [uart_data_bits_p-1:0] csum_q, csum_d;
`endif

   logic [num_src_p-1:0]        rr_grant_oh;
   logic [src_id_width_lp-1:0]  rr_grant_id;
   logic                        rr_v;
   bp_fpga_host_nbf_s           nbf_sel;
   logic [num_src_p-1:0]        yumi;
   logic                        tx_v;
   logic [uart_data_bits_p-1:0] tx_data;

   bsg_arb_round_robin #(
      .width_p (num_src_p)
   ) rr (
      .reqs_i          (nbf_v_i),
      .last_i          (last_grant_q),
      .grant_one_hot_o (rr_grant_oh),
      .grant_id_o      (rr_grant_id),
      .v_o             (rr_v)
   );

   // Select the packet of the source the arbiter is offering this cycle.
   always_comb begin
      nbf_sel = '0;
      for (int k = 0; k < num_src_p; k++) begin
         if (rr_grant_id == src_id_width_lp'(k)) begin
            nbf_sel = nbf_i[k*nbf_width_lp +: nbf_width_lp];
         end
      end
   end

   // Next-state, datapath and handshake logic for the TX sequencer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      shift_d      = shift_q;
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      yumi         = '0;
      tx_v         = 1'b0;
      tx_data      = '0;
      case (state_q)
         e_idle: begin
            if (rr_v) begin
               yumi         = rr_grant_oh;
               shift_d      = nbf_sel;
               grant_id_d   = rr_grant_id;
               last_grant_d = rr_grant_id;
               cnt_d        = '0;
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
               csum_d       = '0;
`endif
               state_d      = e_send;
            end
         end
         e_send: begin
            tx_v    = 1'b1;
            tx_data = shift_q[uart_data_bits_p-1:0];
            if (tx_ready_and_i) begin
               shift_d = shift_q >> uart_data_bits_p;
               cnt_d   = cnt_q + cnt_width_lp'(1);
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
               csum_d  = csum_q ^ shift_q[uart_data_bits_p-1:0];
`endif
               if (cnt_q == last_byte_lp) begin
                  cnt_d   = '0;
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
                  state_d = e_csum;
`else
                  state_d = e_idle;
`endif
               end
            end
         end
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
         e_csum: begin
            tx_v    = 1'b1;
            tx_data = csum_q;
            if (tx_ready_and_i) begin
               state_d = e_idle;
            end
         end
`endif
         default: begin
            state_d = e_idle;
         end
      endcase
   end

   // Control state; reset drops any packet in flight and re-arms source 0.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q      <= e_idle;
         cnt_q        <= '0;
         last_grant_q <= src_id_width_lp'(num_src_p - 1);
         grant_id_q   <= '0;
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
`ifdef BP_FPGA_HOST_TX_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   // Packet shift register; its contents are only observed while sending.
   always_ff @(posedge clk_i) begin
      shift_q <= shift_d;
   end

   assign nbf_yumi_o = yumi & {num_src_p{reset_n_i}};
   assign tx_v_o     = tx_v;
   assign tx_data_o  = tx_data;
   assign busy_o     = (state_q != e_idle);
   assign grant_id_o = grant_id_q;

endmodule
